// File: rtl/ex_multicycle.sv
// ex_multicycle -- execute stage with the EX/MEM output register built in.
//
// Single-cycle logic, shift and add/sub/compare results are registered one
// cycle after acceptance. Divide uses a radix-2 restoring FSM and holds
// stallreq_o high until the result is ready. The divider is only built when
// the EX_DIV_EN macro is defined. Without it, the DIV class returns 0 in one
// cycle, and stallreq_o and rem_o are tied to 0.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   valid_i, flush_i    instruction present / kill in-flight work
//   aluop_i, alusel_i   operation subtype / result class
//   wd_i, wreg_i        destination address / register write enable
//   reg1_i, reg2_i      source operands
//   stallreq_o          combinational stall request to pipeline control
//   valid_o, wd_o, wreg_o, wdata_o, rem_o   registered EX/MEM bundle
//
// Handshake: an instruction is accepted on a rising edge where
// valid_i & !stallreq_o & !flush_i. While stallreq_o is high, upstream holds
// every input stable.
module ex_multicycle #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic              flush_i,
    input  logic [7:0]        aluop_i,
    input  logic [2:0]        alusel_i,
    input  logic [REG_AW-1:0] wd_i,
    input  logic              wreg_i,
    input  logic [DATA_W-1:0] reg1_i,
    input  logic [DATA_W-1:0] reg2_i,
    output logic              stallreq_o,
    output logic              valid_o,
    output logic [REG_AW-1:0] wd_o,
    output logic              wreg_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic [DATA_W-1:0] rem_o
);
    localparam int SH_W = $clog2(DATA_W);

    localparam logic [2:0] SEL_LOGIC = 3'b001;
    localparam logic [2:0] SEL_SHIFT = 3'b010;
    localparam logic [2:0] SEL_ARITH = 3'b100;
    localparam logic [2:0] SEL_DIV   = 3'b110;

    localparam logic [7:0] OP_AND  = 8'h24;
    localparam logic [7:0] OP_OR   = 8'h25;
    localparam logic [7:0] OP_XOR  = 8'h26;
    localparam logic [7:0] OP_NOR  = 8'h27;
    localparam logic [7:0] OP_SLL  = 8'h7C;
    localparam logic [7:0] OP_SRL  = 8'h02;
    localparam logic [7:0] OP_SRA  = 8'h03;
    localparam logic [7:0] OP_ADD  = 8'h20;
    localparam logic [7:0] OP_SUB  = 8'h23;
    localparam logic [7:0] OP_SLT  = 8'h2A;
    localparam logic [7:0] OP_SLTU = 8'h2B;
    localparam logic [7:0] OP_DIV  = 8'h1A;
    localparam logic [7:0] OP_DIVU = 8'h1B;

    logic              is_div_op;
    logic [SH_W-1:0]   shamt;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] div_quo;
    logic [DATA_W-1:0] div_rem;

    assign is_div_op = (alusel_i == SEL_DIV) &&
                       ((aluop_i == OP_DIV) || (aluop_i == OP_DIVU));
    assign shamt     = reg1_i[SH_W-1:0];

    // Single-cycle result; DIV and unknown classes fall through to 0.
    always_comb begin
        alu_res = '0;
        case (alusel_i)
            SEL_LOGIC: begin
                case (aluop_i)
                    OP_AND:  alu_res = reg1_i & reg2_i;
                    OP_OR:   alu_res = reg1_i | reg2_i;
                    OP_XOR:  alu_res = reg1_i ^ reg2_i;
                    OP_NOR:  alu_res = ~(reg1_i | reg2_i);
                    default: alu_res = '0;
                endcase
            end
            SEL_SHIFT: begin
                case (aluop_i)
                    OP_SLL:  alu_res = reg2_i << shamt;
                    OP_SRL:  alu_res = reg2_i >> shamt;
                    OP_SRA:  alu_res = $signed(reg2_i) >>> shamt;
                    default: alu_res = '0;
                endcase
            end
            SEL_ARITH: begin
                case (aluop_i)
                    OP_ADD:  alu_res = reg1_i + reg2_i;
                    OP_SUB:  alu_res = reg1_i - reg2_i;
                    OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(reg1_i) < $signed(reg2_i))};
                    OP_SLTU: alu_res = {{(DATA_W-1){1'b0}}, (reg1_i < reg2_i)};
                    default: alu_res = '0;
                endcase
            end
            default: alu_res = '0;
        endcase
    end

`ifdef EX_DIV_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } div_state_t;

    localparam logic [SH_W-1:0] CNT_LAST = SH_W'(DATA_W - 1);

    div_state_t        state_q, state_d;
    logic [SH_W-1:0]   cnt_q;
    logic [DATA_W-1:0] quo_q;     // dividend magnitude, shifted into the quotient
    logic [DATA_W-1:0] prem_q;    // partial remainder
    logic [DATA_W-1:0] dsr_q;     // divisor magnitude
    logic              neg_quo_q;
    logic              neg_rem_q;
    logic              dvz_q;

    logic              div_start;
    logic              sgn_op;
    logic [DATA_W-1:0] a_mag;
    logic [DATA_W-1:0] b_mag;
    logic [DATA_W:0]   shifted;
    logic [DATA_W:0]   trial;

    assign div_start = (state_q == S_IDLE) && valid_i && is_div_op && !flush_i;
    assign sgn_op    = (aluop_i == OP_DIV);
    assign a_mag     = (sgn_op && reg1_i[DATA_W-1]) ? ('0 - reg1_i) : reg1_i;
    assign b_mag     = (sgn_op && reg2_i[DATA_W-1]) ? ('0 - reg2_i) : reg2_i;

    // A negative trial difference shows up as bit DATA_W set.
    assign shifted   = {prem_q, quo_q[DATA_W-1]};
    assign trial     = shifted - {1'b0, dsr_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (div_start) begin
                    state_d = (reg2_i == '0) ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        stallreq_o = valid_i && is_div_op && (state_q != S_DONE) && !flush_i;
        div_quo    = dvz_q ? '1 : (neg_quo_q ? ('0 - quo_q) : quo_q);
        // Divide-by-zero remainder is the dividend, still held on reg1_i.
        div_rem    = dvz_q ? reg1_i : (neg_rem_q ? ('0 - prem_q) : prem_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            quo_q     <= '0;
            prem_q    <= '0;
            dsr_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dvz_q     <= 1'b0;
        end else if (div_start) begin
            cnt_q     <= '0;
            quo_q     <= a_mag;
            prem_q    <= '0;
            dsr_q     <= b_mag;
            neg_quo_q <= sgn_op && (reg1_i[DATA_W-1] ^ reg2_i[DATA_W-1]);
            neg_rem_q <= sgn_op && reg1_i[DATA_W-1];
            dvz_q     <= (reg2_i == '0);
        end else if (state_q == S_BUSY) begin
            cnt_q <= cnt_q + 1'b1;
            if (!trial[DATA_W]) begin
                prem_q <= trial[DATA_W-1:0];
                quo_q  <= {quo_q[DATA_W-2:0], 1'b1};
            end else begin
                prem_q <= shifted[DATA_W-1:0];
                quo_q  <= {quo_q[DATA_W-2:0], 1'b0};
            end
        end
    end
`else
    assign stallreq_o = 1'b0;
    assign div_quo    = '0;
    assign div_rem    = '0;
`endif

    // EX/MEM register: flush/reset clears the bundle; a bubble clears only
    // valid and write enable so the data fields hold.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            valid_o <= 1'b0;
            wreg_o  <= 1'b0;
            wd_o    <= '0;
            wdata_o <= '0;
            rem_o   <= '0;
        end else if (valid_i && !stallreq_o) begin
            valid_o <= 1'b1;
            wreg_o  <= wreg_i;
            wd_o    <= wd_i;
            wdata_o <= is_div_op ? div_quo : alu_res;
            rem_o   <= is_div_op ? div_rem : '0;
        end else begin
            valid_o <= 1'b0;
            wreg_o  <= 1'b0;
        end
    end
endmodule
